// File: rtl/draw_arbiter.sv
// Shared card source: synchronizes three active-low request keys, latches presses and
// round-robin grants the free-running card counter to one requester at a time.
module draw_arbiter #(
  parameter int unsigned CARD_MAX = 10,
  parameter int unsigned HOLD     = 4
) (
  input  logic       Clock,
  input  logic       reset_n,
  input  logic [2:0] key_n,
  input  logic [2:0] req_en,
  output logic [4:0] card,
  output logic [2:0] card_valid,
  output logic [2:0] pending,
  output logic       busy
);

  typedef enum logic [1:0] {StIdle, StGrant, StHold} state_e;

  state_e     r_state;
  logic [4:0] r_cnt;
  logic [2:0] r_s1;
  logic [2:0] r_s2;
  logic [2:0] r_prev;
  logic [2:0] r_pending;
  logic [1:0] r_last;
  logic [1:0] r_sel;
  logic [3:0] r_hold_cnt;
  logic [4:0] r_card;
  logic [2:0] r_card_valid;

  state_e     w_state_nxt;
  logic [4:0] w_cnt_nxt;
  logic [2:0] w_fall;
  logic [2:0] w_elig;
  logic [1:0] w_pick;
  logic [2:0] w_clr;
  logic [2:0] w_pending_nxt;
  logic [1:0] w_last_nxt;
  logic [1:0] w_sel_nxt;
  logic [3:0] w_hold_nxt;
  logic [4:0] w_card_nxt;
  logic [2:0] w_valid_nxt;

  assign w_cnt_nxt = (r_cnt == 5'(CARD_MAX)) ? 5'd1 : r_cnt + 5'd1;
  assign w_fall    = r_prev & ~r_s2;
  assign w_elig    = r_pending & req_en;

  // First eligible requester scanning upward from the one after the last winner.
  always_comb begin
    w_pick = r_last;
    case (r_last)
      2'd0: begin
        if (w_elig[1])      w_pick = 2'd1;
        else if (w_elig[2]) w_pick = 2'd2;
        else                w_pick = 2'd0;
      end
      2'd1: begin
        if (w_elig[2])      w_pick = 2'd2;
        else if (w_elig[0]) w_pick = 2'd0;
        else                w_pick = 2'd1;
      end
      default: begin
        if (w_elig[0])      w_pick = 2'd0;
        else if (w_elig[1]) w_pick = 2'd1;
        else                w_pick = 2'd2;
      end
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_sel_nxt   = r_sel;
    w_last_nxt  = r_last;
    w_hold_nxt  = r_hold_cnt;
    w_card_nxt  = r_card;
    w_valid_nxt = 3'b000;
    w_clr       = 3'b000;
    case (r_state)
      StIdle: begin
        if (|w_elig) begin
          w_sel_nxt   = w_pick;
          w_state_nxt = StGrant;
        end
      end
      StGrant: begin
        w_card_nxt  = r_cnt;
        w_valid_nxt = 3'b001 << r_sel;
        w_clr       = 3'b001 << r_sel;
        w_last_nxt  = r_sel;
        w_hold_nxt  = 4'(HOLD - 1);
        w_state_nxt = StHold;
      end
      StHold: begin
        if (r_hold_cnt == 4'd0) w_state_nxt = StIdle;
        else                    w_hold_nxt  = r_hold_cnt - 4'd1;
      end
      default: w_state_nxt = StIdle;
    endcase
    // A press landing in its own grant cycle survives the clear.
    w_pending_nxt = (r_pending & ~w_clr) | w_fall;
  end

  always_ff @(posedge Clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= StIdle;
      r_cnt        <= 5'd1;
      r_s1         <= 3'b111;
      r_s2         <= 3'b111;
      r_prev       <= 3'b111;
      r_pending    <= 3'b000;
      r_last       <= 2'd2;
      r_sel        <= 2'd0;
      r_hold_cnt   <= 4'd0;
      r_card       <= 5'd0;
      r_card_valid <= 3'b000;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_s1         <= key_n;
      r_s2         <= r_s1;
      r_prev       <= r_s2;
      r_pending    <= w_pending_nxt;
      r_last       <= w_last_nxt;
      r_sel        <= w_sel_nxt;
      r_hold_cnt   <= w_hold_nxt;
      r_card       <= w_card_nxt;
      r_card_valid <= w_valid_nxt;
    end
  end

  assign card       = r_card;
  assign card_valid = r_card_valid;
  assign pending    = r_pending;
  assign busy       = (r_state == StGrant) || (r_state == StHold);

endmodule

// File: tb/tb_draw_arbiter.sv
// Directed bench for draw_arbiter: latency, round-robin order, counter value, masking,
// press during own grant and reset in the middle of a hold.
module tb_draw_arbiter;

  logic       Clock;
  logic       reset_n;
  logic [2:0] key_n;
  logic [2:0] req_en;
  logic [4:0] card;
  logic [2:0] card_valid;
  logic [2:0] pending;
  logic       busy;

  int checks = 0;
  int errors = 0;
  int e_cnt;

  draw_arbiter #(
    .CARD_MAX(10),
    .HOLD    (4)
  ) dut (
    .Clock     (Clock),
    .reset_n   (reset_n),
    .key_n     (key_n),
    .req_en    (req_en),
    .card      (card),
    .card_valid(card_valid),
    .pending   (pending),
    .busy      (busy)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  // Clock edges seen since reset was released.
  always @(posedge Clock or negedge reset_n) begin
    if (!reset_n) e_cnt <= 0;
    else          e_cnt <= e_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge Clock);
  endtask

  task automatic wait_valid(input int budget, output int cyc, output logic [2:0] v);
    cyc = 0;
    v   = 3'b000;
    while (cyc < budget && v == 3'b000) begin
      @(negedge Clock);
      cyc++;
      v = card_valid;
    end
  endtask

  task automatic reset_pulse();
    @(negedge Clock);
    reset_n = 1'b0;
    @(negedge Clock);
    reset_n = 1'b1;
  endtask

  int          cyc;
  logic [2:0]  v;
  int          pulses;
  logic [31:0] exp_card;

  initial begin
    reset_n = 1'b0;
    key_n   = 3'b111;
    req_en  = 3'b111;
    #3;
    check("rst_card", card, 0);
    check("rst_valid", card_valid, 0);
    check("rst_pending", pending, 0);
    check("rst_busy", busy, 0);
    step(2);
    reset_n = 1'b1;

    // Single press on requester 0
    step(10);
    key_n = 3'b110;
    step(3);
    check("t1_pending_e2", pending, 3'b001);
    check("t1_busy_e2", busy, 0);
    step(1);
    check("t1_busy_e3", busy, 1);
    check("t1_valid_e3", card_valid, 0);
    step(1);
    exp_card = 32'((e_cnt - 1) % 10 + 1);
    check("t1_valid_e4", card_valid, 3'b001);
    check("t1_card", card, exp_card);
    check("t1_card_range", (card >= 5'd1 && card <= 5'd10), 1);
    check("t1_pending_e4", pending, 0);
    key_n = 3'b111;
    for (int k = 5; k <= 7; k++) begin
      step(1);
      check("t1_busy_hold", busy, 1);
      check("t1_valid_hold", card_valid, 0);
    end
    step(1);
    check("t1_busy_e8", busy, 0);

    // All three pressed together after reset
    reset_pulse();
    step(3);
    key_n = 3'b000;
    wait_valid(20, cyc, v);
    check("t2_first", v, 3'b001);
    check("t2_first_lat", cyc, 5);
    key_n = 3'b111;
    wait_valid(20, cyc, v);
    check("t2_second", v, 3'b010);
    check("t2_second_gap", cyc, 6);
    wait_valid(20, cyc, v);
    check("t2_third", v, 3'b100);
    check("t2_third_gap", cyc, 6);
    check("t2_pending", pending, 0);

    // Counter value after a free run past several wraps
    reset_pulse();
    step(25);
    key_n = 3'b101;
    wait_valid(20, cyc, v);
    exp_card = 32'((e_cnt - 1) % 10 + 1);
    check("t3_valid", v, 3'b010);
    check("t3_lat", cyc, 5);
    check("t3_card", card, exp_card);
    check("t3_card_range", (card >= 5'd1 && card <= 5'd10), 1);
    key_n = 3'b111;
    step(6);

    // Masked requester 1 stays pending until re-enabled
    req_en = 3'b101;
    key_n  = 3'b001;
    wait_valid(20, cyc, v);
    check("t4_grant2", v, 3'b100);
    key_n  = 3'b111;
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      step(1);
      if (card_valid != 3'b000) pulses++;
    end
    check("t4_no_grant1", pulses, 0);
    check("t4_pending1", pending, 3'b010);
    req_en = 3'b111;
    wait_valid(10, cyc, v);
    check("t4_grant1", v, 3'b010);
    check("t4_grant1_lat", cyc, 2);
    step(6);

    // Second press of key 0 lands in its own grant cycle
    key_n = 3'b110;
    step(1);
    key_n = 3'b111;
    step(1);
    key_n = 3'b110;
    step(1);
    check("t5_pending_e2", pending, 3'b001);
    step(1);
    check("t5_busy_e3", busy, 1);
    step(1);
    check("t5_valid_e4", card_valid, 3'b001);
    check("t5_pending_kept", pending, 3'b001);
    key_n = 3'b111;
    wait_valid(10, cyc, v);
    check("t5_regrant", v, 3'b001);
    check("t5_regrant_gap", cyc, 6);
    check("t5_pending_clear", pending, 0);
    step(6);

    // Reset during hold, with requester 2 still pending
    key_n = 3'b001;
    wait_valid(20, cyc, v);
    check("t6_grant1", v, 3'b010);
    key_n = 3'b111;
    step(2);
    reset_n = 1'b0;
    #1;
    check("t6_card", card, 0);
    check("t6_valid", card_valid, 0);
    check("t6_pending", pending, 0);
    check("t6_busy", busy, 0);
    step(1);
    reset_n = 1'b1;
    pulses  = 0;
    for (int i = 0; i < 20; i++) begin
      step(1);
      if (card_valid != 3'b000) pulses++;
    end
    check("t6_no_valid", pulses, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/draw_arbiter.md
# draw_arbiter

Shares one free-running 1..CARD_MAX card source between three requesters: blackjack player (0), blackjack dealer (1) and roulette/slots (2). It synchronizes and edge-detects the raw active-low push-button lines and latches each press as a pending request. A round-robin arbiter then serves the requests one at a time, returning the sampled card and a one-hot valid pulse to the winner. It sits between the board KEYs and the game state machines and replaces the separate per-game random number generators.

## Interface
Parameters:
- CARD_MAX, 10: highest card value; range 1..31.
- HOLD, 4: idle cycles enforced after each grant; range 1..15.

Ports:
- Clock  in  1  system clock (50 MHz).
- reset_n  in  1  asynchronous, active-low reset.
- key_n  in  3  raw active-low request buttons, bit i = requester i; asynchronous to Clock.
- req_en  in  3  synchronous per-requester enable; 0 masks arbitration for that requester.
- card  out  5  last granted card value, held until the next grant.
- card_valid  out  3  one-hot, one-cycle pulse naming the requester that owns `card`.
- pending  out  3  latched, not-yet-served requests.
- busy  out  1  high while the state is GRANT or HOLD.

## Operation
- Reset values (asynchronous): cnt=1, card=0, card_valid=0, pending=0, sync stages=3'b111, prev=3'b111, last=2, state=IDLE, hold_cnt=0, busy=0.
- Card source: `cnt` increments every cycle: 1, 2, ..., CARD_MAX, then wraps to 1. It never holds 0. It runs in every state.
- Input path per bit:
  - Two-flop synchronizer s1 -> s2.
  - prev <= s2.
  - fall = prev & ~s2.
- Pending register: pending[i] <= (pending[i] & ~clr[i]) | fall[i]. When set and clear hit the same cycle, set wins, so a new press during its own grant is retained. A repeated press while already pending is absorbed; presses are not counted.
- Eligible set: elig = pending & req_en. A masked request stays pending until it is granted or reset.
- FSM states:
  - IDLE, with elig != 0: choose the first eligible index scanning from last+1 mod 3. Store it as `sel` and go to GRANT.
  - IDLE, with elig == 0: stay in IDLE.
  - GRANT (one cycle): card <= cnt, card_valid <= onehot(sel), clr[sel]=1, last <= sel, hold_cnt <= HOLD-1, next state HOLD.
  - HOLD: card_valid <= 0. If hold_cnt == 0, go to IDLE; otherwise decrement hold_cnt.
- `sel` is not re-evaluated in GRANT. If req_en[sel] drops during GRANT, the grant still completes.
- card_valid is 0 in every cycle other than the one following the GRANT edge.
- Reset mid-operation: all state clears immediately. An in-flight grant is lost with no valid pulse, and pending is cleared.

## Timing
- Let edge 0 be the first Clock edge that samples key_n[i]=0 after it was 1:
  - s2 low after edge 1.
  - pending[i] high after edge 2.
  - FSM enters GRANT after edge 3.
  - card and card_valid[i] are registered at edge 4 and valid for the cycle after edge 4.
- Minimum press-to-valid latency: 4 cycles.
- Grant spacing: consecutive card_valid pulses are at least HOLD+2 cycles apart.
- Throughput: one card per HOLD+2 cycles when requests are continuously pending.
- `card` equals the value of `cnt` during the cycle before the GRANT edge.
- Round-robin fairness: with all three requesters continuously pending and enabled, grants follow 0,1,2,0,... Any requester waits at most 2 other grants.
- busy is high from the edge that enters GRANT until the edge that returns to IDLE.

## Test plan
- Reset then single press: assert reset_n=0, release, hold key_n=3'b111 for 10 cycles, then drive key_n[0] low at edge 0. Required: card_valid=3'b001 exactly in the cycle after edge 4, card in 1..10 equal to the model cnt, pending[0] back to 0 after edge 4, busy high for HOLD+1=5 cycles.
- Simultaneous press of all three after reset (last=2). Required: grant order 0,1,2; card_valid pulses spaced exactly 6 cycles apart; pending reaches 0 after the third grant.
- Counter wrap: free-run 25 cycles, then press key 1. Required: card equals ((cycles since reset) mod 10)+1 per the model, and never 0 or 11.
- Masking: set req_en=3'b101 and press keys 1 and 2. Required: only requester 2 is granted; pending[1] stays 1. Raising req_en[1] then produces grant 1 in the next IDLE cycle.
- Press during own grant: hold key 0 low, release, and press again so fall[0] lands in the GRANT cycle. Required: pending[0] remains 1 and a second grant to 0 follows after HOLD.
- Reset mid-HOLD: pulse reset_n=0 two cycles after a grant. Required: card=0, card_valid=0, pending=0, busy=0 immediately, and no further valid pulse without a new press.
